// File: rtl/i2c_pkg.sv
// Shared encodings for the parametrised I2C master: FSM states, SCL quarter phases and
// the bus levels that signal ACK and NACK.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StAddr,
    StAckA,
    StWdata,
    StAckW,
    StRdata,
    StMack,
    StStop
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic AckLvl  = 1'b0;
  localparam logic NackLvl = 1'b1;

endpackage

// File: rtl/i2c_clk_div.sv
// Quarter-period divider: pulses tick every CLK_DIV clocks while enabled and walks a
// 2-bit SCL phase; dropping enable returns both to zero so each transaction starts at Q0.
module i2c_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       tick,
  output logic       qstart,
  output logic [1:0] phase
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic [1:0]      phase_q;

  assign tick   = en && (cnt_q == CntW'(CLK_DIV - 1));
  assign qstart = en && (cnt_q == '0);
  assign phase  = phase_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else if (!en) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else if (tick) begin
      cnt_q   <= '0;
      phase_q <= phase_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_param.sv
// Single-master I2C controller: one START/address/data/STOP transaction per request,
// write or read, with slave-NACK reporting. SDA is open-drain (pulled low or released).
module i2c_master_param
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned LEN_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [6:0]             addr,
  input  logic                   rw,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   valid,
  output logic                   nack_err,
  output logic                   i2c_scl,
  inout  wire                    i2c_sda
);

  i2c_state_e             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   rw_q, rw_d;
  logic [8*MAX_BYTES-1:0] wdata_q, wdata_d, wnext;
  logic [8*MAX_BYTES-1:0] rdata_q, rdata_d;
  logic [7:0]             shift_q, shift_d;
  logic                   smp_q, smp_d;
  logic                   nack_q, nack_d;
  logic                   valid_q, valid_d;

  logic       tick, qstart, bit_end, last_byte, sda_low;
  logic [1:0] phase;

  i2c_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .tick  (tick),
    .qstart(qstart),
    .phase (phase)
  );

  assign busy      = (state_q != StIdle);
  assign valid     = valid_q;
  assign nack_err  = nack_q;
  assign rdata     = rdata_q;
  assign bit_end   = tick && (phase == Q3);
  assign last_byte = (byte_cnt_q == len_q - LEN_W'(1));
  assign wnext     = wdata_q >> 8;
  assign i2c_sda   = sda_low ? 1'b0 : 1'bz;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    shift_d    = shift_q;
    smp_d      = smp_q;
    nack_d     = nack_q;
    valid_d    = 1'b0;
    if (qstart && (phase == Q2)) smp_d = i2c_sda;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StStart;
          shift_d    = {addr, rw};
          rw_d       = rw;
          len_d      = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
          wdata_d    = wdata;
          nack_d     = 1'b0;
          byte_cnt_d = '0;
          bit_cnt_d  = 3'd7;
        end
      end
      StStart: if (bit_end) state_d = StAddr;
      StAddr, StWdata: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd0) begin
            state_d = (state_q == StAddr) ? StAckA : StAckW;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end
        end
      end
      StAckA: begin
        if (bit_end) begin
          bit_cnt_d = 3'd7;
          if (smp_q == NackLvl) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else if (len_q == '0) begin
            state_d = StStop;
          end else begin
            state_d = rw_q ? StRdata : StWdata;
            shift_d = wdata_q[7:0];
          end
        end
      end
      StAckW: begin
        if (bit_end) begin
          bit_cnt_d = 3'd7;
          if (smp_q == NackLvl) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else if (last_byte) begin
            state_d = StStop;
          end else begin
            byte_cnt_d = byte_cnt_q + LEN_W'(1);
            wdata_d    = wnext;
            shift_d    = wnext[7:0];
            state_d    = StWdata;
          end
        end
      end
      StRdata: begin
        if (bit_end) begin
          shift_d = {shift_q[6:0], smp_q};
          if (bit_cnt_q == 3'd0) begin
            rdata_d[{byte_cnt_q, 3'b000} +: 8] = {shift_q[6:0], smp_q};
            state_d = StMack;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end
      StMack: begin
        if (bit_end) begin
          bit_cnt_d = 3'd7;
          if (last_byte) begin
            state_d = StStop;
          end else begin
            byte_cnt_d = byte_cnt_q + LEN_W'(1);
            state_d    = StRdata;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // START and STOP move SDA while SCL is high; every other phase toggles SCL on Q2.
  always_comb begin
    i2c_scl = 1'b1;
    sda_low = 1'b0;
    unique case (state_q)
      StIdle: ;
      StStart: begin
        i2c_scl = (phase != Q3);
        sda_low = (phase != Q0);
      end
      StStop: begin
        i2c_scl = (phase != Q0);
        sda_low = (phase != Q3);
      end
      StAddr, StWdata: begin
        i2c_scl = phase[1];
        sda_low = ~shift_q[7];
      end
      StMack: begin
        i2c_scl = phase[1];
        sda_low = ~last_byte;
      end
      default: i2c_scl = phase[1];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      shift_q    <= 8'h00;
      smp_q      <= 1'b1;
      nack_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      shift_q    <= shift_d;
      smp_q      <= smp_d;
      nack_q     <= nack_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: doc/i2c_master_param.md
Name: i2c_master_param

Overview:
Parametrised successor to the team's single-byte I2C write engine. It is a single-master I2C controller that runs one complete transaction per request: START, 7-bit address plus R/W, then 0..MAX_BYTES data bytes, then STOP. It supports both write and read, drives SCL from a programmable divider, checks slave ACKs and reports NACK errors. It sits between the protocol-select logic and the open-drain I2C pins.

Parameters:
CLK_DIV, 4, system clocks per SCL quarter-period (>=1); one SCL bit = 4*CLK_DIV clocks
MAX_BYTES, 4, maximum data bytes per transaction (>=1)
LEN_W, 3, width of len; must hold MAX_BYTES (clog2(MAX_BYTES+1))

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse; accepted only when busy=0
addr  input  7  slave address, sent MSB first
rw  input  1  0=write, 1=read
len  input  LEN_W  number of data bytes; 0 = address-only probe
wdata  input  8*MAX_BYTES  write bytes; byte k = wdata[8k+7:8k], byte 0 sent first
rdata  output  8*MAX_BYTES  read bytes, same packing as wdata
busy  output  1  high from the cycle after accept through the end of STOP
valid  output  1  one-cycle pulse when the transaction completes
nack_err  output  1  slave NACK seen in the last transaction; held until the next accept
i2c_scl  output  1  serial clock; idle high
i2c_sda  inout  1  open-drain: driven 0 or released (Z); never driven 1

Behaviour:
- Reset (reset=0, async): busy=0, valid=0, nack_err=0, rdata=0, i2c_scl=1, i2c_sda=Z, state=IDLE, divider cleared. Mid-transaction reset releases the bus immediately; no STOP is generated.
- Accept: in IDLE with start=1, latch addr, rw, len, wdata. A len greater than MAX_BYTES is clamped to MAX_BYTES. Clear nack_err. busy=1 from the next cycle. start while busy=1 is ignored.
- Quarter tick: a divider pulses every CLK_DIV clocks while busy. Each bit has 4 quarters:
  - Q0: SCL low, SDA updated.
  - Q1: SCL low.
  - Q2: SCL high, SDA sampled at the start of Q2.
  - Q3: SCL high.
- States (each bit/phase = 4 quarters):
  - IDLE
  - START: SDA released then pulled low while SCL high, SCL low at end.
  - ADDR: 8 bits, addr[6:0] then rw.
  - ACK_A: SDA released; a sampled 1 sets nack_err and goes to STOP.
  - If len=0 -> STOP; else WDATA (rw=0) or RDATA (rw=1).
  - WDATA: 8 bits MSB first.
  - ACK_W: NACK sets nack_err -> STOP; otherwise next byte or STOP after the last.
  - RDATA: SDA released, 8 bits sampled MSB first into rdata byte k.
  - MACK: master drives 0 (ACK) after each byte except the last, which gets released (NACK); then next byte or STOP.
  - STOP: SDA low with SCL low, SCL high, then SDA released while SCL high.
- Completion: after the STOP's final quarter, valid=1 for one cycle and busy=0 in that same cycle; state returns to IDLE. A new start may be accepted in the cycle after valid.
- Latency: accept-to-valid = 4*CLK_DIV*(11+9*len) clocks for a fully ACKed transaction. On NACK, the remaining bytes are skipped.
- SDA changes only while SCL is low, except the START and STOP edges.
- rdata bytes beyond len keep their previous value.
- SCL is never stretched; slave clock stretching is unsupported.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings (IDLE, START, ADDR, ACK_A, WDATA, ACK_W, RDATA, MACK, STOP),
  - quarter-phase constants Q0..Q3,
  - the ACK/NACK level constants.
- One sub-module, i2c_clk_div: a CLK_DIV counter producing the quarter tick and a 2-bit phase, with enable and async active-low reset.

Test Plan:
1. CLK_DIV=4, addr=7'h50, rw=0, len=2, wdata[15:0]=16'hA55A, slave ACKs all -> bus shows 0xA0, ACK, 0x5A, ACK, 0xA5, ACK, STOP. valid at exactly 4*4*(11+18)=464 clocks after accept; nack_err=0.
2. addr=7'h3C, rw=1, len=3, slave returns 0x11, 0x22, 0x33 -> rdata[23:0]=24'h332211. Master ACK, ACK, NACK, then STOP; nack_err=0.
3. addr=7'h12, rw=0, len=2, no slave (SDA pulled up) -> NACK at ACK_A, no data bits, STOP, valid pulse, nack_err=1 until the next accept.
4. len=0 probe, addr=7'h68 ACKed -> START, 0xD0, ACK, STOP only. valid after 4*CLK_DIV*11 clocks.
5. Write len=4: assert start again mid-transfer -> ignored. Then drop reset during byte 2 -> SCL=1 and SDA=Z immediately, busy=0, valid never pulses.
6. Slave NACKs write byte 1 of 3 -> byte 2 is not sent, STOP follows ACK_W, nack_err=1.
